// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch PC generator and its branch target buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  // Default vectors for a 32-bit PC.
  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'hBFC00380;

  // 2-bit saturating direction counter encoding. Bit 1 is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Geometry of the default BTB configuration.
  localparam int BTB_PC_W          = 32;
  localparam int BTB_DEPTH_DEFAULT = 16;
  localparam int BTB_IDX_W         = $clog2(BTB_DEPTH_DEFAULT);
  localparam int BTB_TAG_W         = BTB_PC_W - BTB_IDX_W - 2;

  // One BTB entry. Only 'valid' is reset; the other fields are qualified by it.
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational on pc_i; updates land on the next rising clk.
// Backpressure: none; updates are always accepted, independent of fetch stalls.
//
// Ports:
//   clk, rst            clock, async active-high reset (clears valid bits only)
//   pc_i                fetch PC to look up
//   upd_valid_i/pc/target/taken   resolved control-flow update from Execute
//   hit_taken_o         entry valid, tag matches and counter predicts taken
//   hit_target_o        stored target of the indexed entry (word aligned)
module pc_btb
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i,
  output logic                  hit_taken_o,
  output logic [DATA_WIDTH-1:0] hit_target_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [BTB_DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [DATA_WIDTH-1:0] target_q [BTB_DEPTH];
  logic [1:0]            ctr_q    [BTB_DEPTH];

  // Lookup side: reads the current array contents, so a same-cycle update
  // to the same index only becomes visible after the clock edge.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx       = pc_i[IDX_W+1:2];
  assign lk_tag       = pc_i[DATA_WIDTH-1:IDX_W+2];
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign hit_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign hit_target_o = target_q[lk_idx];

  // Update side.
  logic [IDX_W-1:0]      up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic [DATA_WIDTH-1:0] up_tgt;
  logic                  up_en;
  logic                  up_hit;
  logic                  alloc;
  logic                  tk_hit;
  logic                  nt_hit;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[DATA_WIDTH-1:IDX_W+2];
  assign up_tgt = {upd_target_i[DATA_WIDTH-1:2], 2'b00};
  // An update presented while reset is high is dropped.
  assign up_en  = upd_valid_i && !rst;
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign alloc  = up_en &&  upd_taken_i && !up_hit;
  assign tk_hit = up_en &&  upd_taken_i &&  up_hit;
  assign nt_hit = up_en && !upd_taken_i &&  up_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload storage carries no reset; valid_q qualifies every read.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= up_tgt;
      ctr_q[up_idx]    <= CTR_WT;
    end else if (tk_hit) begin
      target_q[up_idx] <= up_tgt;
      ctr_q[up_idx]    <= ctr_inc(ctr_q[up_idx]);
    end else if (nt_hit) begin
      ctr_q[up_idx]    <= ctr_dec(ctr_q[up_idx]);
    end
  end

  // Byte-offset bits are architecturally zero and deliberately not used.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register, next-PC priority select and optional BTB prediction.
// Latency: next PC registered on each rising clk; pc_plus4_o and prediction are combinational on pc_o.
// Backpressure: stall_i holds pc_o; trap_i and redirect_i override a stall.
//
// Optional feature: define PC_GEN_BTB_EN to instantiate the branch target
// buffer. Without it the upd_* inputs are ignored and no prediction is made.
//
// Ports:
//   clk, rst                     clock, async active-high reset (pc_o = RESET_VECTOR)
//   stall_i                      hold current PC
//   redirect_i, redirect_pc_i    Execute redirect and its target
//   trap_i                       trap request, loads TRAP_VECTOR
//   upd_valid_i/pc/target/taken  resolved branch update for the BTB
//   pc_o, pc_plus4_o             current fetch PC and PC+4
//   pred_taken_o, pred_target_o  prediction for pc_o (target = pc_plus4_o when not taken)
module pc_gen
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = PC_TRAP_VECTOR,
  parameter int                    BTB_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_i,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_target_o
);

  // Vectors are forced to word alignment so pc_o[1:0] can never be nonzero.
  localparam logic [DATA_WIDTH-1:0] RESET_PC = {RESET_VECTOR[DATA_WIDTH-1:2], 2'b00};
  localparam logic [DATA_WIDTH-1:0] TRAP_PC  = {TRAP_VECTOR[DATA_WIDTH-1:2], 2'b00};

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  btb_taken;
  logic [DATA_WIDTH-1:0] btb_target;

  // Wraps modulo 2^DATA_WIDTH.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

`ifdef PC_GEN_BTB_EN
  pc_btb #(
    .DATA_WIDTH (DATA_WIDTH),
    .BTB_DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_q),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i),
    .hit_taken_o  (btb_taken),
    .hit_target_o (btb_target)
  );
`else
  assign btb_taken  = 1'b0;
  assign btb_target = pc_plus4;

  logic unused_upd;
  assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i};
`endif

  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_taken ? btb_target : pc_plus4;

  always_comb begin
    pc_next = pc_plus4;
    if (trap_i) begin
      pc_next = TRAP_PC;
    end else if (redirect_i) begin
      pc_next = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else if (stall_i) begin
      pc_next = pc_q;
    end else if (pred_taken_o) begin
      pc_next = pred_target_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;

  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc_i[1:0];

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] TV = 32'hBFC00380;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          total = 0;
  int          bad   = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .trap_i        (trap),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_target_i  (upd_target),
    .upd_taken_i   (upd_taken),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change only at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; redirect = 0; redirect_pc = '0; trap = 0;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid = 1; upd_pc = p; upd_target = t; upd_taken = tk;
  endtask

  task automatic goto(input logic [31:0] target);
    redirect = 1; redirect_pc = target;
    exp_q.push_back({target[31:2], 2'b00});
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1;
    #1;
    total++; if (pc_o !== RV) begin bad++; $display("FAIL reset_async pc_o got %h want %h", pc_o, RV); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_pred got %b want 0", pred_taken_o); end
    tick(); tick();
    total++; if (pc_o !== RV) begin bad++; $display("FAIL reset_hold pc_o got %h want %h", pc_o, RV); end
    rst = 0;
    total++; if (pc_plus4_o !== RV + 32'd4) begin bad++; $display("FAIL reset_plus4 got %h want %h", pc_plus4_o, RV + 32'd4); end
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(RV + 32'(4 * i));
      tick();
      exp_pc = exp_q.pop_front();
      total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL reset_seq[%0d] pc_o got %h want %h", i, pc_o, exp_pc); end
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1;
    goto(32'h0000_1000);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL redirect_over_stall pc_o got %h want %h", pc_o, exp_pc); end
    for (int i = 0; i < 2; i++) begin
      stall = 1;
      exp_q.push_back(32'h0000_1000);
      tick();
      exp_pc = exp_q.pop_front();
      total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL stall_hold[%0d] pc_o got %h want %h", i, pc_o, exp_pc); end
    end
    idle();
    exp_q.push_back(32'h0000_1004);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL stall_release pc_o got %h want %h", pc_o, exp_pc); end
  endtask

  task automatic test_trap();
    trap = 1; redirect = 1; stall = 1; redirect_pc = 32'h0000_5000;
    exp_q.push_back(TV);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL trap_priority pc_o got %h want %h", pc_o, exp_pc); end
    exp_q.push_back(TV + 32'd4);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL trap_advance pc_o got %h want %h", pc_o, exp_pc); end
  endtask

  task automatic test_btb_train();
    // Allocate while a redirect is in flight elsewhere.
    goto(32'h0000_0800);
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL train_redirect pc_o got %h want %h", pc_o, exp_pc); end

    goto(32'h0000_1000);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL train_fetch pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== BTB_ON) begin bad++; $display("FAIL train_pred_taken got %b want %b", pred_taken_o, BTB_ON); end
    total++; if (pred_target_o !== (BTB_ON ? 32'h0000_2000 : 32'h0000_1004)) begin
      bad++; $display("FAIL train_pred_target got %h want %h", pred_target_o, BTB_ON ? 32'h0000_2000 : 32'h0000_1004);
    end
    exp_q.push_back(BTB_ON ? 32'h0000_2000 : 32'h0000_1004);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL train_next_pc pc_o got %h want %h", pc_o, exp_pc); end

    // Same index, different tag: must not predict.
    goto(32'h0000_1040);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL alias_fetch pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_pred_taken got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h0000_1044) begin bad++; $display("FAIL alias_pred_target got %h want 00001044", pred_target_o); end
    exp_q.push_back(32'h0000_1044);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL alias_next_pc pc_o got %h want %h", pc_o, exp_pc); end

    // Two not-taken updates drop the counter from WT to SNT.
    goto(32'h0000_1000);
    upd(32'h0000_1000, 32'h0000_2000, 1'b0);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL untrain_fetch pc_o got %h want %h", pc_o, exp_pc); end
    stall = 1;
    upd(32'h0000_1000, 32'h0000_2000, 1'b0);
    exp_q.push_back(32'h0000_1000);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL untrain_hold pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL untrain_pred_taken got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h0000_1004) begin bad++; $display("FAIL untrain_pred_target got %h want 00001004", pred_target_o); end
    exp_q.push_back(32'h0000_1004);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL untrain_next_pc pc_o got %h want %h", pc_o, exp_pc); end
  endtask

  task automatic test_saturate();
    // Target low bits are ignored: 0x3106 stores as 0x3104.
    goto(32'h0000_3010);
    upd(32'h0000_3010, 32'h0000_3106, 1'b1);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL sat_fetch pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== BTB_ON) begin bad++; $display("FAIL sat_alloc_pred got %b want %b", pred_taken_o, BTB_ON); end
    total++; if (pred_target_o !== (BTB_ON ? 32'h0000_3104 : 32'h0000_3014)) begin
      bad++; $display("FAIL sat_alloc_target got %h want %h", pred_target_o, BTB_ON ? 32'h0000_3104 : 32'h0000_3014);
    end
    for (int i = 0; i < 2; i++) begin
      stall = 1;
      upd(32'h0000_3010, 32'h0000_3104, 1'b1);
      exp_q.push_back(32'h0000_3010);
      tick(); idle();
      exp_pc = exp_q.pop_front();
      total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL sat_inc_hold[%0d] pc_o got %h want %h", i, pc_o, exp_pc); end
    end
    // Counter saturated at ST; one not-taken leaves it at WT (still taken).
    stall = 1;
    upd(32'h0000_3010, 32'h0000_3104, 1'b0);
    exp_q.push_back(32'h0000_3010);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL sat_dec_hold pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== BTB_ON) begin bad++; $display("FAIL sat_high_pred got %b want %b", pred_taken_o, BTB_ON); end
    // Second not-taken: lookup in this cycle still sees WT, next cycle WNT.
    stall = 1;
    upd(32'h0000_3010, 32'h0000_3104, 1'b0);
    #1;
    total++; if (pred_taken_o !== BTB_ON) begin bad++; $display("FAIL same_cycle_pred got %b want %b", pred_taken_o, BTB_ON); end
    exp_q.push_back(32'h0000_3010);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL sat_dec2_hold pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL sat_after_update_pred got %b want 0", pred_taken_o); end
    exp_q.push_back(32'h0000_3014);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL sat_next_pc pc_o got %h want %h", pc_o, exp_pc); end
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFF);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL wrap_align pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got %h want 00000000", pc_plus4_o); end
    total++; if (pred_target_o !== 32'h0) begin bad++; $display("FAIL wrap_pred_target got %h want 00000000", pred_target_o); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pc = exp_q.pop_front();
      total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL wrap_seq[%0d] pc_o got %h want %h", i, pc_o, exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    goto(32'h0000_0040);
    upd(32'h0000_0040, 32'h0000_0080, 1'b1);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL midrst_setup pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== BTB_ON) begin bad++; $display("FAIL midrst_setup_pred got %b want %b", pred_taken_o, BTB_ON); end

    // Pending redirect and update are present when reset arrives.
    redirect = 1; redirect_pc = 32'h0000_7000;
    upd(32'h0000_0050, 32'h0000_0090, 1'b1);
    #2 rst = 1;
    #1;
    total++; if (pc_o !== RV) begin bad++; $display("FAIL midrst_async pc_o got %h want %h", pc_o, RV); end
    tick();
    total++; if (pc_o !== RV) begin bad++; $display("FAIL midrst_drop_redirect pc_o got %h want %h", pc_o, RV); end
    idle();
    rst = 0;
    exp_q.push_back(RV + 32'd4);
    tick();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL midrst_first_edge pc_o got %h want %h", pc_o, exp_pc); end

    goto(32'h0000_0040);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL midrst_refetch pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL midrst_btb_cleared got %b want 0", pred_taken_o); end
    goto(32'h0000_0050);
    tick(); idle();
    exp_pc = exp_q.pop_front();
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL midrst_fetch50 pc_o got %h want %h", pc_o, exp_pc); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL midrst_upd_dropped got %b want 0", pred_taken_o); end
  endtask

  initial begin
    test_reset();
    test_redirect_stall();
    test_trap();
    test_btb_train();
    test_saturate();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
